// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central hazard/forwarding controller for a 5-stage MIPS pipeline.
//   Produces EX operand forwarding selects, ID branch-compare forwarding selects, stage
//   hold/flush controls, and a multi-cycle (mul/div) EX occupancy FSM.
//   Optional feature macro: HAZ_PERF_EN enables saturating stall/flush perf counters;
//   without it stall_cnt/flush_cnt are tied to zero and no counter flops exist.
// Ports:
//   clock, reset_n                   clock, synchronous active-low reset
//   id_rs/id_rt, id_use_rs/id_use_rt ID-stage sources and their use flags
//   id_branch, id_jump, br_taken     control-flow info (branch stage per BR_IN_ID)
//   ex_rs/ex_rt/ex_rd, ex_regwrite, ex_memread, ex_mc_start   ID_EX fields
//   mem_rd, mem_regwrite, mem_memread                         EX_MEM fields
//   wb_rd, wb_regwrite                                        MEM_WB fields
//   fwd_a/fwd_b                      EX operand select: 00 regfile, 01 MEM_WB, 10 EX_MEM
//   fwd_id_a/fwd_id_b                ID compare operand from EX_MEM
//   pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, ex_busy
//   stall_cnt, flush_cnt             perf counters
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MC_LAT   = 4,
  parameter int unsigned BR_IN_ID = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              br_taken,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_mc_start,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_id_a,
  output logic              fwd_id_b,
  output logic              pc_hold,
  output logic              if_id_hold,
  output logic              id_ex_hold,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned CntW    = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam int unsigned LastCnt = (MC_LAT > 2) ? MC_LAT - 2 : 0;

  typedef enum logic {StIdle, StBusy} state_t;

  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;  // op in EX just finished; its still-high start must not retrigger

  // Register 0 never produces a match.
  function automatic logic hit(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

  function automatic logic id_src_hit(input logic [REG_AW-1:0] rd);
    return (id_use_rs && hit(rd, id_rs)) || (id_use_rt && hit(rd, id_rt));
  endfunction

  logic mc_accept, busy, load_use, br_stall, redirect;

  always_comb begin
    mc_accept = (MC_LAT > 1) && (state_q == StIdle) && ex_mc_start && !done_q;
    busy      = mc_accept || (state_q == StBusy);
    load_use  = ex_memread && id_src_hit(ex_rd);
    br_stall  = (BR_IN_ID != 0) && id_branch &&
                ((ex_regwrite && id_src_hit(ex_rd)) || (mem_memread && id_src_hit(mem_rd)));
    redirect  = id_jump || (id_branch && br_taken);
  end

  always_comb begin
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    fwd_id_a    = 1'b0;
    fwd_id_b    = 1'b0;
    pc_hold     = 1'b0;
    if_id_hold  = 1'b0;
    id_ex_hold  = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_busy     = 1'b0;
    if (reset_n) begin
      if (mem_regwrite && !mem_memread && hit(mem_rd, ex_rs)) fwd_a = 2'b10;
      else if (wb_regwrite && hit(wb_rd, ex_rs))              fwd_a = 2'b01;
      if (mem_regwrite && !mem_memread && hit(mem_rd, ex_rt)) fwd_b = 2'b10;
      else if (wb_regwrite && hit(wb_rd, ex_rt))              fwd_b = 2'b01;
      if (BR_IN_ID != 0) begin
        fwd_id_a = mem_regwrite && !mem_memread && hit(mem_rd, id_rs);
        fwd_id_b = mem_regwrite && !mem_memread && hit(mem_rd, id_rt);
      end
      if (busy) begin
        // Freeze everything up to EX; the datapath bubbles EX_MEM using ex_busy.
        ex_busy    = 1'b1;
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
        id_ex_hold = 1'b1;
      end else if (load_use || br_stall) begin
        pc_hold     = 1'b1;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
      end else if (redirect) begin
        if_id_flush = 1'b1;
        if ((BR_IN_ID == 0) && id_branch && br_taken) id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (mc_accept) begin
            if (MC_LAT == 2) begin
              done_q <= 1'b1;
            end else begin
              state_q <= StBusy;
              cnt_q   <= CntW'(1);
            end
          end
        end
        StBusy: begin
          if (cnt_q == CntW'(LastCnt)) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((pc_hold || if_id_hold || id_ex_hold) && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if ((if_id_flush || id_ex_flush) && (flush_q != '1))         flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed bench for pipeline_hazard_ctrl (MC_LAT=4, BR_IN_ID=1, CNT_W=4).
// Expected output vectors are queued when a step is driven and compared at the falling edge.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;
`ifdef HAZ_PERF_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  // {fwd_a, fwd_b, fwd_id_a, fwd_id_b, pc_hold, if_id_hold, id_ex_hold,
  //  if_id_flush, id_ex_flush, ex_busy}
  localparam logic [11:0] ENone  = 12'b00_00_0_0_0_0_0_0_0_0;
  localparam logic [11:0] EStall = 12'b00_00_0_0_1_1_0_0_1_0;
  localparam logic [11:0] EBusy  = 12'b00_00_0_0_1_1_1_0_0_1;
  localparam logic [11:0] EIfFl  = 12'b00_00_0_0_0_0_0_1_0_0;
  localparam logic [11:0] EFa01  = 12'b01_00_0_0_0_0_0_0_0_0;
  localparam logic [11:0] EF1010 = 12'b10_10_0_0_0_0_0_0_0_0;
  localparam logic [11:0] EF0101 = 12'b01_01_0_0_0_0_0_0_0_0;
  localparam logic [11:0] EBrFwd = 12'b00_00_1_0_0_0_0_1_0_0;

  logic clock = 1'b0;
  logic reset_n;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_use_rs, id_use_rt, id_branch, id_jump, br_taken;
  logic ex_regwrite, ex_memread, ex_mc_start, mem_regwrite, mem_memread, wb_regwrite;
  logic [1:0] fwd_a, fwd_b;
  logic fwd_id_a, fwd_id_b, pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, ex_busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  logic [11:0] sb_q[$];
  string       tag_q[$];

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(
    .REG_AW(AW), .MC_LAT(4), .BR_IN_ID(1), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_branch(id_branch), .id_jump(id_jump), .br_taken(br_taken),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_mc_start(ex_mc_start),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_busy(ex_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic clr();
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_branch = 1'b0; id_jump = 1'b0; br_taken = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_rd = '0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_mc_start = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0; mem_memread = 1'b0;
    wb_rd = '0; wb_regwrite = 1'b0;
  endtask

  // lw $2 in EX, add $3,$2,$4 in ID
  task automatic set_lu();
    clr();
    ex_rd = 5'd2; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rs = 5'd2; id_rt = 5'd4; id_use_rs = 1'b1; id_use_rt = 1'b1;
  endtask

  // One clock cycle with the current inputs; compares outputs at the falling edge.
  task automatic step(input string tag, input logic [11:0] e);
    logic [11:0] obs, exp;
    string t;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clock);
    obs = {fwd_a, fwd_b, fwd_id_a, fwd_id_b, pc_hold, if_id_hold, id_ex_hold,
           if_id_flush, id_ex_flush, ex_busy};
    exp = sb_q.pop_front();
    t   = tag_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", t, obs, exp);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] es, input logic [CW-1:0] ef);
    logic [CW-1:0] xs, xf;
    xs = Perf ? es : '0;
    xf = Perf ? ef : '0;
    checks++;
    assert (stall_cnt === xs) else begin
      errors++;
      $error("FAIL %s_stall observed %0d expected %0d", tag, stall_cnt, xs);
    end
    checks++;
    assert (flush_cnt === xf) else begin
      errors++;
      $error("FAIL %s_flush observed %0d expected %0d", tag, flush_cnt, xf);
    end
  endtask

  initial begin
    // Outputs gated to zero while reset is held, even with a hazard present.
    reset_n = 1'b0;
    set_lu();
    step("reset_gate", ENone);
    chk_cnt("reset_cnt", 4'd0, 4'd0);
    reset_n = 1'b1;

    // Load-use: one stall, bubble, then MEM_WB forward.
    set_lu();
    step("lu_stall", EStall);
    clr(); mem_rd = 5'd2; mem_regwrite = 1'b1; mem_memread = 1'b1;
    id_rs = 5'd2; id_rt = 5'd4; id_use_rs = 1'b1; id_use_rt = 1'b1;
    step("lu_bubble", ENone);
    clr(); wb_rd = 5'd2; wb_regwrite = 1'b1; ex_rs = 5'd2; ex_rt = 5'd4;
    step("lu_fwd_wb", EFa01);

    // EX forwarding priority and reg 0.
    clr(); mem_rd = 5'd2; mem_regwrite = 1'b1; wb_rd = 5'd2; wb_regwrite = 1'b1;
    ex_rs = 5'd2; ex_rt = 5'd2;
    step("fwd_mem_pri", EF1010);
    mem_memread = 1'b1;
    step("fwd_load_wb", EF0101);
    clr(); mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    step("fwd_r0", ENone);
    clr(); ex_memread = 1'b1; ex_regwrite = 1'b1; id_use_rs = 1'b1; id_use_rt = 1'b1;
    step("lu_r0", ENone);

    // add $2 ; beq $2,$0 taken: stall, then ID forward and flush.
    clr(); ex_rd = 5'd2; ex_regwrite = 1'b1;
    id_rs = 5'd2; id_use_rs = 1'b1; id_use_rt = 1'b1; id_branch = 1'b1; br_taken = 1'b1;
    step("bs_ex", EStall);
    ex_rd = '0; ex_regwrite = 1'b0; mem_rd = 5'd2; mem_regwrite = 1'b1;
    step("br_fwd_taken", EBrFwd);
    clr();
    step("br_idle", ENone);
    mem_rd = 5'd3; mem_regwrite = 1'b1; mem_memread = 1'b1;
    id_rt = 5'd3; id_use_rt = 1'b1; id_branch = 1'b1;
    step("bs_mem_load", EStall);
    clr(); id_branch = 1'b1;
    step("br_not_taken", ENone);
    clr(); id_jump = 1'b1;
    step("jump", EIfFl);

    // Multi-cycle op held in EX with a jump waiting in ID.
    clr(); ex_mc_start = 1'b1; id_jump = 1'b1;
    step("mc_busy0", EBusy);
    step("mc_busy1", EBusy);
    step("mc_busy2", EBusy);
    step("mc_done", EIfFl);
    ex_mc_start = 1'b0;
    step("mc_after", EIfFl);

    // Reset during BUSY returns the FSM to IDLE.
    clr(); ex_mc_start = 1'b1;
    step("rb_busy0", EBusy);
    reset_n = 1'b0;
    step("rb_in_reset", ENone);
    reset_n = 1'b1; ex_mc_start = 1'b0;
    step("rb_idle", ENone);
    ex_mc_start = 1'b1;
    step("rb_restart0", EBusy);
    step("rb_restart1", EBusy);
    step("rb_restart2", EBusy);
    step("rb_end", ENone);

    // Perf counters: 20 load-use stall cycles saturate a 4-bit counter.
    clr(); reset_n = 1'b0;
    step("perf_reset", ENone);
    reset_n = 1'b1;
    chk_cnt("perf_clr", 4'd0, 4'd0);
    set_lu();
    for (int i = 0; i < 5; i++) step("perf_stall", EStall);
    chk_cnt("perf_5", 4'd5, 4'd5);
    for (int i = 0; i < 15; i++) step("perf_stall", EStall);
    chk_cnt("perf_sat", 4'd15, 4'd15);
    clr(); id_jump = 1'b1;
    step("perf_jump", EIfFl);
    chk_cnt("perf_hold", 4'd15, 4'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
